// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS datapath: PC, IR, register file, ALU latches and step FSM; optional trace port via DATAPATH_TRACE_EN.
// Latency: 4 cycles per ALU/jump instruction, 5 per load/store, plus any memory wait states.
// Backpressure: imem_req/dmem_req held with stable address/data until the matching ready; ready without req is ignored.
module multicycle_datapath #(
    parameter int Dbits = 32,
    parameter int Nreg  = 32,
    parameter logic [Dbits-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       pcsel,
    input  logic [1:0]       wasel,
    input  logic [1:0]       wdsel,
    input  logic [1:0]       asel,
    input  logic             sext,
    input  logic             bsel,
    input  logic [4:0]       alufn,
    input  logic             wr,
    input  logic             rd,
    input  logic             werf,
    output logic [31:0]      instr,
    output logic             Z,
    output logic             imem_req,
    output logic [Dbits-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [Dbits-1:0] dmem_addr,
    output logic [Dbits-1:0] dmem_wdata,
    input  logic             dmem_ready,
    input  logic [Dbits-1:0] dmem_rdata
`ifdef DATAPATH_TRACE_EN
    ,
    output logic [Dbits-1:0] debug,
    output logic [Dbits-1:0] debug_pc,
    output logic [31:0]      retired
`endif
);
    localparam int Abits = $clog2(Nreg);
    localparam int SHW   = $clog2(Dbits);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t            state_q;
    logic [Dbits-1:0]  pc_q, pc4_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0]       instr_q;
    logic              z_q, imem_req_q, dmem_req_q, dmem_we_q;
    logic [Dbits-1:0]  rf_q [Nreg];

    logic [Abits-1:0]  rs_idx, rt_idx, waddr_d;
    logic [Dbits-1:0]  rs_val, rt_val;
    logic [Dbits-1:0]  sign_imm, imm_d, alu_a_d, alu_b_d, alu_d;
    logic [Dbits-1:0]  wdata_d, pc_next_d;
    logic              rf_we_d;

`ifdef DATAPATH_TRACE_EN
    logic [Dbits-1:0]  debug_q, debug_pc_q;
    logic [31:0]       retired_q;
    assign debug    = debug_q;
    assign debug_pc = debug_pc_q;
    assign retired  = retired_q;
`endif

    assign instr      = instr_q;
    assign Z          = z_q;
    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;

    assign rs_idx = Abits'(instr_q[25:21]);
    assign rt_idx = Abits'(instr_q[20:16]);
    assign rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];

    assign sign_imm = {{(Dbits-16){instr_q[15]}}, instr_q[15:0]};
    assign imm_d    = sext ? sign_imm : {{(Dbits-16){1'b0}}, instr_q[15:0]};

    always_comb begin
        alu_a_d = a_q;
        case (asel)
            2'b01:   alu_a_d = {{(Dbits-5){1'b0}}, instr_q[10:6]};
            2'b10:   alu_a_d = Dbits'(16);
            default: alu_a_d = a_q;
        endcase
    end

    assign alu_b_d = bsel ? imm_d : b_q;

    // alufn[1:0]: 01 add/sub, 11 logic, 00 shift (B by A), 10 set-less-than
    always_comb begin
        alu_d = '0;
        case (alufn[1:0])
            2'b01: alu_d = alufn[4] ? (alu_a_d - alu_b_d) : (alu_a_d + alu_b_d);
            2'b11: begin
                case (alufn[3:2])
                    2'b00:   alu_d = alu_a_d & alu_b_d;
                    2'b01:   alu_d = alu_a_d | alu_b_d;
                    2'b10:   alu_d = alu_a_d ^ alu_b_d;
                    default: alu_d = ~(alu_a_d | alu_b_d);
                endcase
            end
            2'b00: begin
                if (!alufn[3])
                    alu_d = alu_b_d << alu_a_d[SHW-1:0];
                else if (!alufn[2])
                    alu_d = alu_b_d >> alu_a_d[SHW-1:0];
                else
                    alu_d = $unsigned($signed(alu_b_d) >>> alu_a_d[SHW-1:0]);
            end
            default: begin
                if (alufn[3])
                    alu_d = {{(Dbits-1){1'b0}}, (alu_a_d < alu_b_d)};
                else
                    alu_d = {{(Dbits-1){1'b0}}, ($signed(alu_a_d) < $signed(alu_b_d))};
            end
        endcase
    end

    always_comb begin
        waddr_d = Abits'(instr_q[15:11]);
        case (wasel)
            2'b01:   waddr_d = rt_idx;
            2'b10:   waddr_d = Abits'(31);
            default: waddr_d = Abits'(instr_q[15:11]);
        endcase
    end

    always_comb begin
        wdata_d = alu_q;
        case (wdsel)
            2'b00:   wdata_d = pc4_q;
            2'b10:   wdata_d = mdr_q;
            default: wdata_d = alu_q;
        endcase
    end

    always_comb begin
        pc_next_d = pc4_q;
        case (pcsel)
            2'b01:   pc_next_d = pc4_q + (sign_imm << 2);
            2'b10:   pc_next_d = {pc4_q[Dbits-1:28], instr_q[25:0], 2'b00};
            2'b11:   pc_next_d = a_q;
            default: pc_next_d = pc4_q;
        endcase
    end

    assign rf_we_d = werf && (wasel != 2'b11) && (waddr_d != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc4_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            instr_q    <= '0;
            z_q        <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
`ifdef DATAPATH_TRACE_EN
            debug_q    <= '0;
            debug_pc_q <= '0;
            retired_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Only the first fetch after reset spends a cycle raising req
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ready) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rs_val;
                    b_q     <= rt_val;
                    pc4_q   <= pc_q + Dbits'(4);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q <= alu_d;
                    z_q   <= (alu_d == '0);
                    if (wr || rd) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= wr;
                        state_q    <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (!dmem_we_q)
                            mdr_q <= dmem_rdata;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    pc_q       <= pc_next_d;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
`ifdef DATAPATH_TRACE_EN
                    retired_q <= retired_q + 32'd1;
                    if (rf_we_d)
                        debug_q <= wdata_d;
                    if (pcsel == 2'b11)
                        debug_pc_q <= a_q;
`endif
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Nreg; i++)
                rf_q[i] <= '0;
        end else if (state_q == S_WB && rf_we_d) begin
            rf_q[waddr_d] <= wdata_d;
        end
    end

endmodule
